fadder_ctrl: RTL and testbench
==============================

Name: fadder_ctrl

Overview:
Initiator-side sequencer for the fadder_top adder/subtractor. It accepts arithmetic requests on a valid/ready interface and drives the adder's load phase (vld_in with en low) and execute phase (en high). It then captures the adder result and returns it on a valid/ready response interface. It sits between a bus-side or testbench-side master and one fadder_top instance.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the attached adder.
CNT_WIDTH, 16, statistics counter width (used only with the optional feature).

Ports:
clk  input  1  clock
reset_n  input  1  synchronous reset, active-low
req_valid  input  1  request valid
req_ready  output  1  request accepted when both high at posedge
req_op  input  1  1 = add, 0 = subtract
req_carry  input  1  carry in (add only)
req_a  input  DATA_WIDTH  operand A
req_b  input  DATA_WIDTH  operand B
add_en  output  1  to adder en
add_op  output  1  to adder op
add_vld_in  output  1  to adder vld_in
add_carry_in  output  1  to adder carry_in
add_op_a  output  DATA_WIDTH  to adder op_a
add_op_b  output  DATA_WIDTH  to adder op_b
add_vld_out  input  1  from adder vld_out
add_carry_out  input  1  from adder carry_out
add_data_out  input  DATA_WIDTH  from adder data_out
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when both high at posedge
rsp_data  output  DATA_WIDTH  result
rsp_carry  output  1  carry out (add) / borrow (sub)
rsp_err  output  1  adder vld_out was low at capture

Behaviour:
- Reset: clk is the clock; reset_n is a synchronous, active-low reset. While reset_n is low at posedge, state goes to IDLE and all outputs and internal registers go to 0; req_ready is 0 during reset. Reset mid-transaction aborts it; the request is dropped and no response is issued.
- FSM states: IDLE, LOAD, EXEC, CAPT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, latch op, carry, a, b into internal registers and go to LOAD. All add_* strobes are 0.
- LOAD (1 cycle): add_vld_in = 1, add_en = 0; add_op_a, add_op_b, add_carry_in driven from the latched registers. Go to EXEC.
- EXEC (1 cycle): add_en = 1, add_vld_in = 0, add_op = latched op. Go to CAPT.
- CAPT (1 cycle): add_en = 0. At posedge, register add_data_out into rsp_data and add_carry_out into rsp_carry. rsp_err = ~add_vld_out. Go to RESP.
- RESP: rsp_valid = 1. rsp_data, rsp_carry and rsp_err are held stable until rsp_ready. On handshake, rsp_valid drops next cycle and state returns to IDLE.
- Latency: rsp_valid rises 3 posedges after the accepting posedge. Minimum accept-to-accept interval is 5 cycles when rsp_ready is held high.
- add_op_a, add_op_b, add_carry_in and add_op hold their last values outside LOAD/EXEC; they are 0 after reset.
- req_ready is 0 in every state except IDLE. There is no queuing.
- add_en and add_vld_in are never high in the same cycle.
- Arithmetic is performed entirely in the adder; the controller does no arithmetic on data.

Optional Feature:
Macro FADDER_CTRL_STATS_EN.
- Defined: adds outputs stat_add_cnt, stat_sub_cnt and stat_flag_cnt, each CNT_WIDTH bits and reset to 0.
  - stat_add_cnt and stat_sub_cnt increment on every response handshake, selected by the latched op.
  - stat_flag_cnt increments on a response handshake with rsp_carry = 1.
  - All counters saturate at all-ones; no wrap-around.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Add: req_op=1, a=0x7F, b=0x01, carry=0, rsp_ready=1 -> rsp_data=0x80, rsp_carry=0, rsp_err=0; rsp_valid 3 cycles after accept.
2. Add with overflow: a=0xFF, b=0x01, carry=1 -> rsp_data=0x01, rsp_carry=1.
3. Subtract with borrow: req_op=0, a=0x05, b=0x09 -> rsp_data=0xFC, rsp_carry=1; then a=0x09, b=0x05 -> 0x04, rsp_carry=0.
4. Backpressure: rsp_ready=0 for 10 cycles while req_valid=1 -> rsp_valid, rsp_data and rsp_carry stable, req_ready=0 throughout; rsp_ready=1 -> IDLE, next request accepted 1 cycle later.
5. Reset mid-EXEC: assert reset_n=0 for 2 cycles -> all outputs 0, no rsp_valid; a following add 0x10+0x20 -> 0x30.
6. With FADDER_CTRL_STATS_EN: 3 adds (one carrying) + 2 subs (one borrowing) -> stat_add_cnt=3, stat_sub_cnt=2, stat_flag_cnt=2.

Source files
------------

// File: rtl/fadder_ctrl.sv
// -----------------------------------------------------------------------------
// fadder_ctrl -- initiator-side sequencer for one fadder_top adder/subtractor.
//
// A request arrives on a valid/ready interface. The controller latches it and
// drives the adder through a load phase (add_vld_in=1, add_en=0) and then an
// execute phase (add_en=1). It captures the adder result and returns it on a
// valid/ready response interface. All arithmetic happens in the adder. Only one
// request is in flight at a time, and there is no queuing.
//
// Optional feature (macro FADDER_CTRL_STATS_EN): saturating counters of add
// and sub responses, and of responses with carry/borrow set.
//
// Parameters:
//   DATA_WIDTH  operand/result width; must match the attached adder
//   CNT_WIDTH   statistics counter width (stats build only)
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_op, req_carry, req_a, req_b   request payload (op 1 = add, 0 = sub)
//   add_en, add_op, add_vld_in,
//   add_carry_in, add_op_a, add_op_b  drive to the adder
//   add_vld_out, add_carry_out,
//   add_data_out                      result from the adder
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_carry, rsp_err      result, carry/borrow, adder-not-valid
//   stat_add_cnt, stat_sub_cnt,
//   stat_flag_cnt                     statistics (FADDER_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module fadder_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic                  req_carry,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  add_en,
  output logic                  add_op,
  output logic                  add_vld_in,
  output logic                  add_carry_in,
  output logic [DATA_WIDTH-1:0] add_op_a,
  output logic [DATA_WIDTH-1:0] add_op_b,
  input  logic                  add_vld_out,
  input  logic                  add_carry_out,
  input  logic [DATA_WIDTH-1:0] add_data_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_err
`ifdef FADDER_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_add_cnt,
  output logic [CNT_WIDTH-1:0]  stat_sub_cnt,
  output logic [CNT_WIDTH-1:0]  stat_flag_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StExec,
    StCapt,
    StResp
  } state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic                  r_op;
  logic                  r_carry;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_carry;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_rsp_hs;

  assign w_accept = req_valid & req_ready;
  assign w_rsp_hs = (r_state == StResp) & rsp_ready;

  // State register plus the request and response payload registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_op        <= 1'b0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op    <= req_op;
        r_carry <= req_carry;
        r_a     <= req_a;
        r_b     <= req_b;
      end
      if (r_state == StCapt) begin
        r_rsp_data  <= add_data_out;
        r_rsp_carry <= add_carry_out;
        r_rsp_err   <= ~add_vld_out;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StLoad;
      StLoad:  w_state_next = StExec;
      StExec:  w_state_next = StCapt;
      StCapt:  w_state_next = StResp;
      StResp:  if (w_rsp_hs) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // req_ready is gated with reset_n so that it reads 0 while reset is held.
  // Without the gate it would read 1, because reset forces the state to IDLE.
  assign req_ready = (r_state == StIdle) & reset_n;

  // The operand outputs come straight from the latch registers. They change
  // only on accept, which is the edge that enters LOAD, so they hold their
  // values at every other time.
  assign add_vld_in   = (r_state == StLoad);
  assign add_en       = (r_state == StExec);
  assign add_op       = r_op;
  assign add_carry_in = r_carry;
  assign add_op_a     = r_a;
  assign add_op_b     = r_b;

  assign rsp_valid = (r_state == StResp);
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_err   = r_rsp_err;

`ifdef FADDER_CTRL_STATS_EN
  logic [CNT_WIDTH-1:0] r_add_cnt;
  logic [CNT_WIDTH-1:0] r_sub_cnt;
  logic [CNT_WIDTH-1:0] r_flag_cnt;

  // All counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_add_cnt  <= '0;
      r_sub_cnt  <= '0;
      r_flag_cnt <= '0;
    end else if (w_rsp_hs) begin
      if (r_op && !(&r_add_cnt)) r_add_cnt <= r_add_cnt + 1'b1;
      if (!r_op && !(&r_sub_cnt)) r_sub_cnt <= r_sub_cnt + 1'b1;
      if (r_rsp_carry && !(&r_flag_cnt)) r_flag_cnt <= r_flag_cnt + 1'b1;
    end
  end

  assign stat_add_cnt  = r_add_cnt;
  assign stat_sub_cnt  = r_sub_cnt;
  assign stat_flag_cnt = r_flag_cnt;
`else
  logic w_unused_cnt_width;
  assign w_unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fadder_ctrl.sv
module tb_fadder_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_op, req_carry;
  logic [7:0] req_a, req_b;
  logic       add_en, add_op, add_vld_in, add_carry_in;
  logic [7:0] add_op_a, add_op_b;
  logic       add_vld_out = 1'b0;
  logic       add_carry_out = 1'b0;
  logic [7:0] add_data_out = 8'h00;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_err;
  logic [7:0] rsp_data;
`ifdef FADDER_CTRL_STATS_EN
  logic [15:0] stat_add_cnt, stat_sub_cnt, stat_flag_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic overlap = 1'b0;
  logic kill_vld = 1'b0;

  always #5 clk = ~clk;

  fadder_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_carry    (req_carry),
    .req_a        (req_a),
    .req_b        (req_b),
    .add_en       (add_en),
    .add_op       (add_op),
    .add_vld_in   (add_vld_in),
    .add_carry_in (add_carry_in),
    .add_op_a     (add_op_a),
    .add_op_b     (add_op_b),
    .add_vld_out  (add_vld_out),
    .add_carry_out(add_carry_out),
    .add_data_out (add_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_carry    (rsp_carry),
    .rsp_err      (rsp_err)
`ifdef FADDER_CTRL_STATS_EN
    ,
    .stat_add_cnt (stat_add_cnt),
    .stat_sub_cnt (stat_sub_cnt),
    .stat_flag_cnt(stat_flag_cnt)
`endif
  );

  // Minimal adder: latches operands on vld_in and computes on en. The result
  // is valid during the following cycle. For subtract, carry_out is the borrow.
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic       m_c = 1'b0;
  always @(posedge clk) begin
    if (add_vld_in) begin
      m_a <= add_op_a;
      m_b <= add_op_b;
      m_c <= add_carry_in;
    end
    if (add_en) begin
      if (add_op) {add_carry_out, add_data_out} <= {1'b0, m_a} + {1'b0, m_b} + {8'h00, m_c};
      else        {add_carry_out, add_data_out} <= {1'b0, m_a} - {1'b0, m_b};
    end
    add_vld_out <= add_en & ~kill_vld;
  end

  always @(negedge clk) if (add_en === 1'b1 && add_vld_in === 1'b1) overlap = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents a request and returns at the negedge where
  // rsp_valid is first seen, checking the adder strobes on the way.
  task automatic send(input string tag, input logic op, input logic c,
                      input logic [7:0] a, input logic [7:0] b);
    int lat;
    req_valid = 1'b1; req_op = op; req_carry = c; req_a = a; req_b = b;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".load_vld_in"}, 32'(add_vld_in), 32'd1);
    check({tag, ".load_en"}, 32'(add_en), 32'd0);
    check({tag, ".load_a"}, 32'(add_op_a), 32'(a));
    check({tag, ".load_b"}, 32'(add_op_b), 32'(b));
    check({tag, ".load_cin"}, 32'(add_carry_in), 32'(c));
    check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({tag, ".exec_en"}, 32'(add_en), 32'd1);
    check({tag, ".exec_vld_in"}, 32'(add_vld_in), 32'd0);
    check({tag, ".exec_op"}, 32'(add_op), 32'(op));
    @(negedge clk);
    check({tag, ".capt_en"}, 32'(add_en), 32'd0);
    check({tag, ".capt_rsp_valid"}, 32'(rsp_valid), 32'd0);
    lat = 2;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, ".latency"}, 32'(lat), 32'd3);
  endtask

  // Called at a negedge with rsp_valid high. Consumes the response.
  task automatic recv(input string tag, input logic [7:0] d, input logic c, input logic e);
    rsp_ready = 1'b1;
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rsp_data"}, 32'(rsp_data), 32'(d));
    check({tag, ".rsp_carry"}, 32'(rsp_carry), 32'(c));
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e));
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_carry = 1'b0;
    req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.strobes", 32'({add_en, add_vld_in}), 32'd0);
    check("rst.operands", 32'({add_op, add_carry_in, add_op_a, add_op_b}), 32'd0);
    check("rst.rsp", 32'({rsp_data, rsp_carry, rsp_err}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst.idle_ready", 32'(req_ready), 32'd1);

    // Reset during EXEC aborts the request. Done first, so the stats count
    // only the transactions that follow.
    req_valid = 1'b1; req_op = 1'b1; req_carry = 1'b0; req_a = 8'hAA; req_b = 8'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort.exec_en", 32'(add_en), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("abort.req_ready", 32'(req_ready), 32'd0);
    check("abort.strobes", 32'({add_en, add_vld_in, rsp_valid}), 32'd0);
    check("abort.operands", 32'({add_op, add_carry_in, add_op_a, add_op_b}), 32'd0);
    check("abort.rsp", 32'({rsp_data, rsp_carry, rsp_err}), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort.no_rsp", 32'(rsp_valid), 32'd0);
    send("abort_next", 1'b1, 1'b0, 8'h10, 8'h20);
    recv("abort_next", 8'h30, 1'b0, 1'b0);

    send("add", 1'b1, 1'b0, 8'h7F, 8'h01);
    recv("add", 8'h80, 1'b0, 1'b0);
    send("add_ovf", 1'b1, 1'b1, 8'hFF, 8'h01);
    recv("add_ovf", 8'h01, 1'b1, 1'b0);
    send("sub_brw", 1'b0, 1'b0, 8'h05, 8'h09);
    recv("sub_brw", 8'hFC, 1'b1, 1'b0);
    send("sub", 1'b0, 1'b0, 8'h09, 8'h05);
    recv("sub", 8'h04, 1'b0, 1'b0);

    // Backpressure: the response holds while a new request waits.
    send("bp", 1'b1, 1'b0, 8'h33, 8'h44);
    req_valid = 1'b1; req_op = 1'b0; req_carry = 1'b0; req_a = 8'h80; req_b = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.hold_valid", 32'(rsp_valid), 32'd1);
      check("bp.hold_data", 32'({rsp_data, rsp_carry}), 32'({8'h77, 1'b0}));
      check("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    recv("bp", 8'h77, 1'b0, 1'b0);
    send("bp_next", 1'b0, 1'b0, 8'h80, 8'h01);
    recv("bp_next", 8'h7F, 1'b0, 1'b0);

    // Adder leaves vld_out low, so the response must flag an error.
    kill_vld = 1'b1;
    send("err", 1'b1, 1'b0, 8'h01, 8'h02);
    recv("err", 8'h03, 1'b0, 1'b1);
    kill_vld = 1'b0;

    check("no_en_vld_overlap", 32'(overlap), 32'd0);
`ifdef FADDER_CTRL_STATS_EN
    // Adds: 10+20, 7F+01, FF+01+1, 33+44, 01+02. Subs: 05-09, 09-05, 80-01.
    // Carry or borrow seen in: FF+01+1 and 05-09.
    check("stat_add", 32'(stat_add_cnt), 32'd5);
    check("stat_sub", 32'(stat_sub_cnt), 32'd3);
    check("stat_flag", 32'(stat_flag_cnt), 32'd2);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
